// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders plus an OR) steps through
// the operands LSB first, taking WIDTH cycles per addition.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, res, res_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             ha0_s, ha0_c, ha1_s, ha1_c;
    logic             bit_sum, carry_next, last_bit;

    half_adder u_ha0 (.x(op_a[0]), .y(op_b[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(ha1_s), .c(ha1_c));

    assign bit_sum    = ha1_s;
    assign carry_next = ha0_c | ha1_c;
    assign last_bit   = (cnt == CNT_LAST);
    // LSB is produced first, so each new bit enters at the MSB and ripples down.
    assign res_next   = {bit_sum, res[WIDTH-1:1]};

    assign busy = (state == ADD);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carryOut <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= carryIn;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    res   <= res_next;
                    carry <= carry_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum      <= res_next;
                        carryOut <= carry_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the scenario tests and
// a 4-bit instance swept over every operand/carry combination.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       start8, cin8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, co4;
    logic [3:0] a4, b4, sum4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .carryIn(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carryOut(co8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .carryIn(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carryOut(co4)
    );

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic c);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Returns the number of negedges waited until done8 is seen (64 on timeout).
    task automatic wait_done8(output int cyc);
        for (cyc = 0; cyc < 64; cyc++) begin
            if (done8) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy8, done8, co8, sum8} !== 11'h0) begin n_bad++;
            $display("FAIL reset8: busy=%b done=%b co=%b sum=%h, required all 0", busy8, done8, co8, sum8); end
        n_cmp++; if ({busy4, done4, co4, sum4} !== 7'h0) begin n_bad++;
            $display("FAIL reset4: busy=%b done=%b co=%b sum=%h, required all 0", busy4, done4, co4, sum4); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int busy_cnt = 0;
        bit done_early = 0;
        issue8(8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (busy8) busy_cnt++;
            if (done8) done_early = 1;
            @(negedge clk);
        end
        n_cmp++; if (busy_cnt !== 8) begin n_bad++;
            $display("FAIL basic_busy_cycles: got %0d required 8", busy_cnt); end
        n_cmp++; if (done_early !== 1'b0) begin n_bad++;
            $display("FAIL basic_done_early: got %b required 0", done_early); end
        n_cmp++; if ({done8, busy8} !== 2'b10) begin n_bad++;
            $display("FAIL basic_done_pulse: done=%b busy=%b required done=1 busy=0", done8, busy8); end
        n_cmp++; if ({co8, sum8} !== 9'h096) begin n_bad++;
            $display("FAIL basic_result: got co=%b sum=%h required co=0 sum=96", co8, sum8); end
        @(negedge clk);
        n_cmp++; if (done8 !== 1'b0) begin n_bad++;
            $display("FAIL basic_done_width: done=%b one cycle later, required 0", done8); end
    endtask

    task automatic test_carry;
        int cyc;
        issue8(8'hFF, 8'h01, 1'b0);
        wait_done8(cyc);
        n_cmp++; if (cyc !== 8) begin n_bad++;
            $display("FAIL carry1_latency: got %0d required 8", cyc); end
        n_cmp++; if ({co8, sum8} !== 9'h100) begin n_bad++;
            $display("FAIL carry1_result: got co=%b sum=%h required co=1 sum=00", co8, sum8); end
        issue8(8'hFF, 8'hFF, 1'b1);
        wait_done8(cyc);
        n_cmp++; if (cyc !== 8) begin n_bad++;
            $display("FAIL carry2_latency: got %0d required 8", cyc); end
        n_cmp++; if ({co8, sum8} !== 9'h1FF) begin n_bad++;
            $display("FAIL carry2_result: got co=%b sum=%h required co=1 sum=ff", co8, sum8); end
    endtask

    task automatic test_start_ignored;
        int cyc;
        int extra = 0;
        issue8(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++;
            $display("FAIL ignore_latency: got %0d required 5", cyc); end
        n_cmp++; if ({co8, sum8} !== 9'h030) begin n_bad++;
            $display("FAIL ignore_result: got co=%b sum=%h required co=0 sum=30", co8, sum8); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++;
            $display("FAIL ignore_second_done: got %0d extra pulses required 0", extra); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int gap = 0;
        bit held = 1;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        wait_done8(cyc);
        n_cmp++; if ({co8, sum8} !== 9'h003) begin n_bad++;
            $display("FAIL b2b_first: got co=%b sum=%h required co=0 sum=03", co8, sum8); end
        a8 = 8'h80; b8 = 8'h80;
        // DONE ignores start, so the held start is taken on the edge after DONE.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) break;
            gap++;
            if ({co8, sum8} !== 9'h003) held = 0;
        end
        start8 = 1'b0;
        n_cmp++; if (gap !== 9) begin n_bad++;
            $display("FAIL b2b_gap: got %0d idle cycles between pulses required 9", gap); end
        n_cmp++; if (held !== 1'b1) begin n_bad++;
            $display("FAIL b2b_sum_hold: sum changed during second ADD, held=%b required 1", held); end
        n_cmp++; if ({co8, sum8} !== 9'h100) begin n_bad++;
            $display("FAIL b2b_second: got co=%b sum=%h required co=1 sum=00", co8, sum8); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        issue8(8'h7F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy8, done8, co8, sum8} !== 11'h0) begin n_bad++;
            $display("FAIL midreset: busy=%b done=%b co=%b sum=%h required all 0", busy8, done8, co8, sum8); end
        reset = 1'b0;
        issue8(8'h02, 8'h03, 1'b0);
        wait_done8(cyc);
        n_cmp++; if (cyc !== 8) begin n_bad++;
            $display("FAIL midreset_latency: got %0d required 8", cyc); end
        n_cmp++; if ({co8, sum8} !== 9'h005) begin n_bad++;
            $display("FAIL midreset_result: got co=%b sum=%h required co=0 sum=05", co8, sum8); end
    endtask

    task automatic test_exhaustive4;
        logic [8:0] v;
        logic [4:0] expect_sum;
        int cyc;
        for (int i = 0; i < 512; i++) begin
            v = i[8:0];
            @(negedge clk);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
            expect_sum = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
            @(negedge clk);
            start4 = 1'b0;
            for (cyc = 0; cyc < 32; cyc++) begin
                if (done4) break;
                @(negedge clk);
            end
            n_cmp++; if (cyc !== 4) begin n_bad++;
                $display("FAIL exh_latency a=%h b=%h c=%b: got %0d required 4", v[3:0], v[7:4], v[8], cyc); end
            n_cmp++; if ({co4, sum4} !== expect_sum) begin n_bad++;
                $display("FAIL exh_result a=%h b=%h c=%b: got %h required %h", v[3:0], v[7:4], v[8], {co4, sum4}, expect_sum); end
            @(negedge clk);
            n_cmp++; if (done4 !== 1'b0) begin n_bad++;
                $display("FAIL exh_done_width a=%h b=%h c=%b: done=%b required 0", v[3:0], v[7:4], v[8], done4); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
